// File: rtl/segment_decoder.sv
// segment_decoder: recovers a 0..63 magnitude from a debounced pair of active-low 7-segment digits
module segment_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_ones,
    input  logic       out_ready,
    input  logic       clr_overrun,
    output logic       out_valid,
    output logic [5:0] out_magnitude,
    output logic       out_error,
    output logic       overrun
);
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic {HOLD, SETTLE} state_t;

    state_t     state, state_n;
    logic [6:0] cap_tens, cap_ones, cap_tens_n, cap_ones_n;
    logic [7:0] count, count_n;
    logic       new_res;
    logic [4:0] tens_dig, ones_dig;
    logic [3:0] tens_val;
    logic [6:0] value;
    logic       dec_err;

    // Active-low segment pattern to {legal, digit}; anything off-table is illegal.
    function automatic logic [4:0] seg2dig(input logic [6:0] s);
        case (s)
            7'h40:   seg2dig = 5'h10;
            7'h79:   seg2dig = 5'h11;
            7'h24:   seg2dig = 5'h12;
            7'h30:   seg2dig = 5'h13;
            7'h19:   seg2dig = 5'h14;
            7'h12:   seg2dig = 5'h15;
            7'h02:   seg2dig = 5'h16;
            7'h78:   seg2dig = 5'h17;
            7'h00:   seg2dig = 5'h18;
            7'h10:   seg2dig = 5'h19;
            default: seg2dig = 5'h00;
        endcase
    endfunction

    // Decode the captured pair; a blank tens digit reads as zero, a blank ones digit is an error.
    always_comb begin
        tens_dig = seg2dig(cap_tens);
        ones_dig = seg2dig(cap_ones);
        tens_val = (cap_tens == BLANK) ? 4'd0 : tens_dig[3:0];
        value    = {3'b0, tens_val} * 7'd10 + {3'b0, ones_dig[3:0]};
        dec_err  = !((cap_tens == BLANK) || tens_dig[4]) || !ones_dig[4] || (value > 7'd63);
    end

    // Change detection has priority; otherwise count confirming cycles while settling.
    always_comb begin
        state_n    = state;
        cap_tens_n = cap_tens;
        cap_ones_n = cap_ones;
        count_n    = count;
        new_res    = 1'b0;
        if ({seg_tens, seg_ones} != {cap_tens, cap_ones}) begin
            cap_tens_n = seg_tens;
            cap_ones_n = seg_ones;
            count_n    = 8'd0;
            state_n    = SETTLE;
        end else if (state == SETTLE) begin
            count_n = count + 8'd1;
            if (count_n == 8'(STABLE_CYCLES)) begin
                new_res = 1'b1;
                state_n = HOLD;
            end
        end
    end

    // Filter state: captured pair, confirm counter and settle/hold state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HOLD;
            cap_tens <= BLANK;
            cap_ones <= BLANK;
            count    <= 8'd0;
        end else begin
            state    <= state_n;
            cap_tens <= cap_tens_n;
            cap_ones <= cap_ones_n;
            count    <= count_n;
        end
    end

    // Result register with valid/ready handshake; an unaccepted result is overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_magnitude <= 6'd0;
            out_error     <= 1'b0;
        end else if (new_res) begin
            out_valid     <= 1'b1;
            out_magnitude <= dec_err ? 6'd0 : value[5:0];
            out_error     <= dec_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a simultaneous set beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun <= 1'b0;
        else if (new_res && out_valid && !out_ready)
            overrun <= 1'b1;
        else if (clr_overrun)
            overrun <= 1'b0;
    end
endmodule

// File: tb/tb_segment_decoder.sv
// tb_segment_decoder: scoreboard-based check of the 7-segment readback decoder
module tb_segment_decoder;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg_tens = 7'h7F;
    logic [6:0] seg_ones = 7'h7F;
    logic       out_ready = 1'b1;
    logic       clr_overrun = 1'b0;
    logic       out_valid;
    logic [5:0] out_magnitude;
    logic       out_error;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] exp_q[$];
    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    segment_decoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .seg_tens(seg_tens), .seg_ones(seg_ones),
        .out_ready(out_ready), .clr_overrun(clr_overrun), .out_valid(out_valid),
        .out_magnitude(out_magnitude), .out_error(out_error), .overrun(overrun)
    );

    always #10 clk = ~clk;

    // Scoreboard: every handshake-accepted result must match the next queued {error, magnitude}.
    always @(negedge clk) begin
        #1;
        if (reset_n && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_unexpected got err=%0b mag=%0d, expected no result", out_error, out_magnitude);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({out_error, out_magnitude} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard_result got err=%0b mag=%0d, expected err=%0b mag=%0d",
                             out_error, out_magnitude, e[6], e[5:0]);
                end
            end
        end
    end

    task automatic apply(input logic [6:0] t, input logic [6:0] o, input int n);
        seg_tens = t;
        seg_ones = o;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        vectors++;
        if ({out_valid, out_magnitude, out_error, overrun} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_values got v=%0b m=%0d e=%0b o=%0b, expected all 0", out_valid, out_magnitude, out_error, overrun);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_blank_idle cycle %0d got out_valid=%0b, expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_latency;
        seg_tens = 7'h79;
        seg_ones = 7'h24;
        exp_q.push_back({1'b0, 6'd12});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== (k == 5)) begin
                miscompares++;
                $display("FAIL latency_valid after %0d edges got %0b, expected %0b", k, out_valid, k == 5);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({1'b0, 6'(i)});
            apply(7'h7F, lut[i], 6);
        end
        vectors++;
        if (overrun !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sweep_done got overrun=%0b pending=%0d, expected 0 and 0", overrun, exp_q.size());
        end
    endtask

    task automatic test_glitch;
        apply(7'h79, 7'h24, 3);
        seg_tens = 7'h30;
        seg_ones = 7'h19;
        exp_q.push_back({1'b0, 6'd34});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== (k == 5) || (k == 5 && out_magnitude !== 6'd34)) begin
                miscompares++;
                $display("FAIL glitch_34 after %0d edges got v=%0b m=%0d, expected v=%0b m=34", k, out_valid, out_magnitude, k == 5);
            end
        end
    endtask

    task automatic test_errors;
        logic [6:0] pt [2] = '{7'h02, 7'h79};
        logic [6:0] po [2] = '{7'h19, 7'h7E};
        for (int i = 0; i < 2; i++) begin
            seg_tens = pt[i];
            seg_ones = po[i];
            exp_q.push_back({1'b1, 6'd0});
            repeat (5) @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_error !== 1'b1 || out_magnitude !== 6'd0) begin
                miscompares++;
                $display("FAIL error_case%0d got v=%0b e=%0b m=%0d, expected v=1 e=1 m=0", i, out_valid, out_error, out_magnitude);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        apply(7'h40, 7'h12, 6);
        apply(7'h40, 7'h78, 6);
        vectors++;
        if (out_valid !== 1'b1 || out_magnitude !== 6'd7 || out_error !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set got v=%0b m=%0d e=%0b o=%0b, expected v=1 m=7 e=0 o=1", out_valid, out_magnitude, out_error, overrun);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || out_valid !== 1'b1 || out_magnitude !== 6'd7) begin
            miscompares++;
            $display("FAIL overrun_clear got o=%0b v=%0b m=%0d, expected o=0 v=1 m=7", overrun, out_valid, out_magnitude);
        end
        exp_q.push_back({1'b0, 6'd7});
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_settle;
        out_ready = 1'b0;
        apply(7'h40, 7'h30, 6);
        apply(7'h40, 7'h10, 2);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_magnitude !== 6'd0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got v=%0b m=%0d o=%0b, expected all 0", out_valid, out_magnitude, overrun);
        end
        seg_tens = 7'h7F;
        seg_ones = 7'h7F;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_result cycle %0d got out_valid=%0b, expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        #5;
        test_reset;
        test_latency;
        test_sweep;
        test_glitch;
        test_errors;
        test_overrun;
        test_reset_mid_settle;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending results, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
